nvdla_apb_arb: RTL and testbench



---
 rtl/nvdla_apb_arb_pkg.sv | 14 +
 rtl/nvdla_apb_arb_rr.sv | 12 +
 rtl/nvdla_apb_arb.sv | 149 ++++++++++++++
 tb/tb_nvdla_apb_arb.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_apb_arb_pkg.sv
// Shared types and constants for the two-port NVDLA configuration APB arbiter.
package nvdla_apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic [31:0] TIMEOUT_RDATA       = 32'hDEAD_BEEF;
    localparam int          DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/nvdla_apb_arb_rr.sv
// Combinational two-way round-robin picker; on a tie the requester not served last wins.
module nvdla_apb_arb_rr (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    assign gnt_valid = |req;
    assign gnt_idx   = (&req) ? ~rr_last : req[1];

endmodule

// File: rtl/nvdla_apb_arb.sv
// Two-port APB arbiter in front of the NVDLA apb2csb bridge, round-robin, grant held per transfer.
// Optional ACCESS-phase timeout with error response: define NVDLA_APB_ARB_TIMEOUT_EN.
import nvdla_apb_arb_pkg::*;

module nvdla_apb_arb #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic          core_clk,
    input  logic          core_rst,
    input  logic          s0_psel,
    input  logic          s0_penable,
    input  logic          s0_pwrite,
    input  logic [AW-1:0] s0_paddr,
    input  logic [DW-1:0] s0_pwdata,
    output logic [DW-1:0] s0_prdata,
    output logic          s0_pready,
    output logic          s0_pslverr,
    input  logic          s1_psel,
    input  logic          s1_penable,
    input  logic          s1_pwrite,
    input  logic [AW-1:0] s1_paddr,
    input  logic [DW-1:0] s1_pwdata,
    output logic [DW-1:0] s1_prdata,
    output logic          s1_pready,
    output logic          s1_pslverr,
    output logic          m_psel,
    output logic          m_penable,
    output logic          m_pwrite,
    output logic [AW-1:0] m_paddr,
    output logic [DW-1:0] m_pwdata,
    input  logic [DW-1:0] m_prdata,
    input  logic          m_pready,
    output logic          arb_busy,
    output logic          arb_owner
);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic          err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          write_q;
    logic          gnt_valid, gnt_idx;
    logic          timeout;
    logic          in_xfer, in_resp;

    nvdla_apb_arb_rr u_rr (
        .req       ({s1_psel, s0_psel}),
        .rr_last   (rr_last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

`ifdef NVDLA_APB_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    assign timeout = (tmo_cnt_q == 32'(TIMEOUT_CYC - 1));

    // Held at zero outside a transfer, so every SETUP starts a fresh count.
    always_ff @(posedge core_clk) begin
        if (core_rst)
            tmo_cnt_q <= '0;
        else if (state_q == ST_ACCESS)
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        else
            tmo_cnt_q <= '0;
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

    // Requests are recognised on psel alone; penable carries no extra information here.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d = ST_SETUP;
                    owner_d = gnt_idx;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (m_pready || timeout) state_d = ST_RESP;
            ST_RESP: begin
                rr_last_d = owner_q;
                state_d   = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            if (state_q == ST_ACCESS)
                err_q <= !m_pready && timeout;
        end
    end

    // Capture registers carry no reset; every output path is gated by the FSM state.
    always_ff @(posedge core_clk) begin
        if (state_q == ST_IDLE && gnt_valid) begin
            addr_q  <= gnt_idx ? s1_paddr  : s0_paddr;
            wdata_q <= gnt_idx ? s1_pwdata : s0_pwdata;
            write_q <= gnt_idx ? s1_pwrite : s0_pwrite;
        end
        if (state_q == ST_ACCESS)
            rdata_q <= m_pready ? m_prdata : DW'(TIMEOUT_RDATA);
    end

    assign in_xfer    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign in_resp    = (state_q == ST_RESP);

    assign m_psel     = in_xfer;
    assign m_penable  = (state_q == ST_ACCESS);
    assign m_pwrite   = in_xfer & write_q;
    assign m_paddr    = in_xfer ? addr_q  : '0;
    assign m_pwdata   = in_xfer ? wdata_q : '0;

    assign s0_pready  = in_resp & ~owner_q;
    assign s1_pready  = in_resp &  owner_q;
    assign s0_prdata  = s0_pready ? rdata_q : '0;
    assign s1_prdata  = s1_pready ? rdata_q : '0;
    assign s0_pslverr = s0_pready & err_q;
    assign s1_pslverr = s1_pready & err_q;

    assign arb_busy   = (state_q != ST_IDLE);
    assign arb_owner  = owner_q;

endmodule

// File: tb/tb_nvdla_apb_arb.sv
// Self-checking bench for nvdla_apb_arb: scripted requesters, a responding bridge model and scoreboards.
module tb_nvdla_apb_arb;

    logic        core_clk, core_rst;
    logic        s0_psel, s0_penable, s0_pwrite, s1_psel, s1_penable, s1_pwrite;
    logic [31:0] s0_paddr, s0_pwdata, s1_paddr, s1_pwdata;
    logic [31:0] s0_prdata, s1_prdata, m_paddr, m_pwdata, m_prdata;
    logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
    logic        m_psel, m_penable, m_pwrite, m_pready, arb_busy, arb_owner;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
        logic        owner;
    } bx_t;

    bx_t         bq[$];
    logic [31:0] rq0[$];
    logic [31:0] rq1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          bridge_waits = 0;
    int          bridge_never = 0;
    int          bw_cnt = 0;

    nvdla_apb_arb #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .s0_psel(s0_psel), .s0_penable(s0_penable), .s0_pwrite(s0_pwrite),
        .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_prdata(s0_prdata),
        .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
        .s1_psel(s1_psel), .s1_penable(s1_penable), .s1_pwrite(s1_pwrite),
        .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_prdata(s1_prdata),
        .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return 32'h1234_5678 + (a - 32'h0000_5000);
    endfunction

    function automatic bx_t mk(input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic own);
        bx_t b;
        b.addr = a; b.wr = wr; b.wd = wd; b.owner = own;
        return b;
    endfunction

    task automatic drive_port(input int p, input logic sel, input logic en, input logic wr,
                              input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            s0_psel = sel; s0_penable = en; s0_pwrite = wr; s0_paddr = a; s0_pwdata = d;
        end else begin
            s1_psel = sel; s1_penable = en; s1_pwrite = wr; s1_paddr = a; s1_pwdata = d;
        end
    endtask

    // Bridge model: answers after bridge_waits ACCESS cycles and checks each ACCESS cycle against the expected transfer.
    initial begin
        m_pready = 1'b0;
        m_prdata = '0;
        forever begin
            @(posedge core_clk); #1;
            if (m_psel && m_penable) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL bridge_unexpected: got transfer at addr %h, expected none", m_paddr);
                end else begin
                    n_cmp++;
                    if (m_paddr !== bq[0].addr) begin
                        n_bad++; $display("FAIL bridge_addr: got %h expected %h", m_paddr, bq[0].addr);
                    end
                    n_cmp++;
                    if (m_pwrite !== bq[0].wr) begin
                        n_bad++; $display("FAIL bridge_write: got %b expected %b", m_pwrite, bq[0].wr);
                    end
                    n_cmp++;
                    if (arb_owner !== bq[0].owner) begin
                        n_bad++; $display("FAIL bridge_owner: got %b expected %b", arb_owner, bq[0].owner);
                    end
                    if (bq[0].wr) begin
                        n_cmp++;
                        if (m_pwdata !== bq[0].wd) begin
                            n_bad++; $display("FAIL bridge_wdata: got %h expected %h", m_pwdata, bq[0].wd);
                        end
                    end
                end
                if (bridge_never == 0 && bw_cnt >= bridge_waits) begin
                    m_pready = 1'b1;
                    m_prdata = rd_model(m_paddr);
                    if (bq.size() > 0) void'(bq.pop_front());
                end else begin
                    m_pready = 1'b0;
                end
                bw_cnt++;
            end else begin
                m_pready = 1'b0;
                m_prdata = '0;
                bw_cnt   = 0;
            end
            if (s0_pready) begin
                n_cmp++;
                if (arb_owner !== 1'b0 || s0_psel !== 1'b1) begin
                    n_bad++; $display("FAIL s0_ready_owner: got owner %b psel %b expected 0/1", arb_owner, s0_psel);
                end
            end
            if (s1_pready) begin
                n_cmp++;
                if (arb_owner !== 1'b1 || s1_psel !== 1'b1) begin
                    n_bad++; $display("FAIL s1_ready_owner: got owner %b psel %b expected 1/1", arb_owner, s1_psel);
                end
            end
        end
    end

    // Full requester-side APB transfer; the expected response is queued at issue and popped at pready.
    task automatic apb_xfer(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_err, input int exp_lat, input string nm);
        int          lat;
        logic        rdy;
        logic [31:0] rd, want;
        logic        err;
        if (p == 0) rq0.push_back(exp_rd); else rq1.push_back(exp_rd);
        drive_port(p, 1'b1, 1'b0, wr, a, d);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 200) begin
            @(posedge core_clk); #1;
            lat++;
            drive_port(p, 1'b1, 1'b1, wr, a, d);
            rdy = (p == 0) ? s0_pready : s1_pready;
        end
        if (!rdy) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_no_ready: got none in %0d cycles, expected at %0d", nm, lat, exp_lat);
            drive_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
            return;
        end
        rd   = (p == 0) ? s0_prdata  : s1_prdata;
        err  = (p == 0) ? s0_pslverr : s1_pslverr;
        want = (p == 0) ? rq0.pop_front() : rq1.pop_front();
        n_cmp++;
        if (rd !== want) begin
            n_bad++; $display("FAIL %s_prdata: got %h expected %h", nm, rd, want);
        end
        n_cmp++;
        if (err !== exp_err) begin
            n_bad++; $display("FAIL %s_pslverr: got %b expected %b", nm, err, exp_err);
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat);
        end
        n_cmp++;
        if (m_psel !== 1'b0) begin
            n_bad++; $display("FAIL %s_m_psel_in_resp: got %b expected 0", nm, m_psel);
        end
        @(posedge core_clk); #1;
        rdy = (p == 0) ? s0_pready : s1_pready;
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_bad++; $display("FAIL %s_ready_width: got %b expected 0", nm, rdy);
        end
        drive_port(p, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic reset_dut();
        core_rst = 1'b1;
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        bridge_waits = 0;
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        repeat (2) @(posedge core_clk);
        #1;
        n_cmp++;
        if ({m_psel, m_penable, m_pwrite, arb_busy, arb_owner} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {m_psel, m_penable, m_pwrite, arb_busy, arb_owner});
        end
        n_cmp++;
        if ({m_paddr, m_pwdata} !== 64'b0) begin
            n_bad++; $display("FAIL reset_m_bus: got %h expected 0", {m_paddr, m_pwdata});
        end
        n_cmp++;
        if ({s0_pready, s0_pslverr, s1_pready, s1_pslverr, s0_prdata, s1_prdata} !== 68'b0) begin
            n_bad++; $display("FAIL reset_s_resp: got %h expected 0", {s0_pready, s0_pslverr, s1_pready, s1_pslverr, s0_prdata, s1_prdata});
        end
        core_rst = 1'b0;
    endtask

    task automatic test_single_read();
        bq.push_back(mk(32'h0000_5000, 1'b0, 32'h0, 1'b0));
        apb_xfer(0, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, 1'b0, 3, "single_read");
        n_cmp++;
        if (arb_owner !== 1'b0 || arb_busy !== 1'b0) begin
            n_bad++; $display("FAIL single_read_after: got owner %b busy %b expected 0/0", arb_owner, arb_busy);
        end
    endtask

    task automatic test_tie_writes();
        reset_dut();
        bq.push_back(mk(32'h0000_5010, 1'b1, 32'hA000_0001, 1'b0));
        bq.push_back(mk(32'h0000_5020, 1'b1, 32'hB000_0002, 1'b1));
        fork
            apb_xfer(0, 1'b1, 32'h0000_5010, 32'hA000_0001, rd_model(32'h0000_5010), 1'b0, 3, "tie_p0");
            apb_xfer(1, 1'b1, 32'h0000_5020, 32'hB000_0002, rd_model(32'h0000_5020), 1'b0, 7, "tie_p1");
        join
    endtask

    task automatic test_back_to_back();
        reset_dut();
        bq.push_back(mk(32'h0000_5100, 1'b1, 32'hC000_0000, 1'b0));
        bq.push_back(mk(32'h0000_5200, 1'b0, 32'h0,         1'b1));
        bq.push_back(mk(32'h0000_5104, 1'b1, 32'hC000_0001, 1'b0));
        bq.push_back(mk(32'h0000_5108, 1'b1, 32'hC000_0002, 1'b0));
        fork
            begin
                apb_xfer(0, 1'b1, 32'h0000_5100, 32'hC000_0000, rd_model(32'h0000_5100), 1'b0, 3, "b2b_p0_0");
                apb_xfer(0, 1'b1, 32'h0000_5104, 32'hC000_0001, rd_model(32'h0000_5104), 1'b0, 7, "b2b_p0_1");
                apb_xfer(0, 1'b1, 32'h0000_5108, 32'hC000_0002, rd_model(32'h0000_5108), 1'b0, 3, "b2b_p0_2");
            end
            apb_xfer(1, 1'b0, 32'h0000_5200, 32'h0, rd_model(32'h0000_5200), 1'b0, 7, "b2b_p1");
        join
    endtask

    task automatic test_wait_states();
        bridge_waits = 5;
        bq.push_back(mk(32'h0000_5400, 1'b0, 32'h0, 1'b1));
        apb_xfer(1, 1'b0, 32'h0000_5400, 32'h0, rd_model(32'h0000_5400), 1'b0, 8, "wait5_p1");
        bridge_waits = 0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] want;
        reset_dut();
        bridge_waits = 20;
        bq.push_back(mk(32'h0000_5700, 1'b1, 32'hCAFE_0001, 1'b0));
        rq0.push_back(rd_model(32'h0000_5700));
        drive_port(0, 1'b1, 1'b0, 1'b1, 32'h0000_5700, 32'hCAFE_0001);
        @(posedge core_clk); #1;
        drive_port(0, 1'b1, 1'b1, 1'b1, 32'h0000_5700, 32'hCAFE_0001);
        @(posedge core_clk); #1;
        n_cmp++;
        if (m_penable !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_in_access: got penable %b expected 1", m_penable);
        end
        core_rst = 1'b1;
        @(posedge core_clk); #1;
        n_cmp++;
        if ({m_psel, m_penable, m_pwrite, arb_busy, arb_owner, s0_pready, s1_pready, m_paddr} !== 39'b0) begin
            n_bad++; $display("FAIL rstmid_cleared: got %h expected 0", {m_psel, m_penable, m_pwrite, arb_busy, arb_owner, s0_pready, s1_pready, m_paddr});
        end
        core_rst = 1'b0;
        bridge_waits = 0;
        lat = 0;
        while (!s0_pready && lat < 50) begin
            @(posedge core_clk); #1;
            lat++;
        end
        want = rq0.pop_front();
        n_cmp++;
        if (lat != 3) begin
            n_bad++; $display("FAIL rstmid_reissue_latency: got %0d expected 3", lat);
        end
        n_cmp++;
        if (s0_prdata !== want) begin
            n_bad++; $display("FAIL rstmid_prdata: got %h expected %h", s0_prdata, want);
        end
        @(posedge core_clk); #1;
        drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

`ifdef NVDLA_APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        reset_dut();
        bridge_never = 1;
        bq.push_back(mk(32'h0000_5800, 1'b0, 32'h0, 1'b0));
        bq.push_back(mk(32'h0000_5900, 1'b0, 32'h0, 1'b1));
        fork
            begin
                apb_xfer(0, 1'b0, 32'h0000_5800, 32'h0, 32'hDEAD_BEEF, 1'b1, 10, "tmo_p0");
                bridge_never = 0;
                if (bq.size() > 0) void'(bq.pop_front());
            end
            apb_xfer(1, 1'b0, 32'h0000_5900, 32'h0, rd_model(32'h0000_5900), 1'b0, 14, "tmo_p1");
        join
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        core_rst = 1'b0;
        drive_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge core_clk); #1;
        test_reset();
        test_single_read();
        test_tie_writes();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
`ifdef NVDLA_APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(posedge core_clk);
        #1;
        n_cmp++;
        if (bq.size() != 0) begin
            n_bad++; $display("FAIL bridge_queue_drained: got %0d left expected 0", bq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
